// File: rtl/cpu_datapath_if.sv
// Control-word, memory and status bundle between the control unit / memories and cpu_datapath.
// master = control unit plus memories side, slave = datapath side.
interface cpu_datapath_if #(
    parameter int unsigned DW  = 16,
    parameter int unsigned IAW = 8,
    parameter int unsigned DAW = 8
);
    logic [3:0]     d_select;
    logic [3:0]     m_select;
    logic [2:0]     operation;
    logic           read;
    logic           write;
    logic           incac;
    logic           incpc;
    logic           resetac;
    logic           resetpc;
    logic           endp;
    logic [IAW-1:0] imem_addr;
    logic [DW-1:0]  imem_rdata;
    logic [DAW-1:0] dmem_addr;
    logic [DW-1:0]  dmem_rdata;
    logic [DW-1:0]  dmem_wdata;
    logic           dmem_we;
    logic [DW-1:0]  ir;
    logic           z;
    logic [DW-1:0]  ac;

    modport master (
        output d_select, m_select, operation, read, write,
        output incac, incpc, resetac, resetpc, endp,
        output imem_rdata, dmem_rdata,
        input  imem_addr, dmem_addr, dmem_wdata, dmem_we, ir, z, ac
    );

    modport slave (
        input  d_select, m_select, operation, read, write,
        input  incac, incpc, resetac, resetpc, endp,
        input  imem_rdata, dmem_rdata,
        output imem_addr, dmem_addr, dmem_wdata, dmem_we, ir, z, ac
    );
endinterface

// File: rtl/cpu_datapath.sv
// Register bank, source bus mux, ALU and memory interface driven by the microcoded control word.
// Control changes on falling edges; all state here updates on rising edges.
module cpu_datapath #(
    parameter int unsigned DW  = 16,
    parameter int unsigned IAW = 8,
    parameter int unsigned DAW = 8
) (
    input logic           clk,
    input logic           rst_n,
    cpu_datapath_if.slave bus_if
);
    localparam logic [3:0] SelR1   = 4'd1;
    localparam logic [3:0] SelR2   = 4'd2;
    localparam logic [3:0] SelR3   = 4'd3;
    localparam logic [3:0] SelR4   = 4'd4;
    localparam logic [3:0] SelR5   = 4'd5;
    localparam logic [3:0] SelAr   = 4'd6;
    localparam logic [3:0] SelAc   = 4'd7;
    localparam logic [3:0] SelIr   = 4'd8;
    localparam logic [3:0] SelPc   = 4'd9;
    localparam logic [3:0] SelMdr  = 4'd10;
    localparam logic [3:0] SelImdr = 4'd11;

    localparam logic [2:0] OpAdd = 3'd2;
    localparam logic [2:0] OpSub = 3'd3;
    localparam logic [2:0] OpShl = 3'd4;
    localparam logic [2:0] OpShr = 3'd5;

    localparam logic [DW-1:0] One = {{(DW-1){1'b0}}, 1'b1};

    logic [DW-1:0] pc_q, pc_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [DW-1:0] ac_q, ac_d;
    logic [DW-1:0] ar_q, ar_d;
    logic [DW-1:0] mdr_q, mdr_d;
    logic [DW-1:0] imdr_q, imdr_d;
    logic [DW-1:0] r_q [5];
    logic [DW-1:0] r_d [5];
    logic          z_q, z_d;

    logic [DW-1:0] bus;
    logic [DW-1:0] alu;
    logic [DW-1:0] ac_inc;

    always_comb begin
        bus = '0;
        case (bus_if.m_select)
            SelR1:   bus = r_q[0];
            SelR2:   bus = r_q[1];
            SelR3:   bus = r_q[2];
            SelR4:   bus = r_q[3];
            SelR5:   bus = r_q[4];
            SelAr:   bus = ar_q;
            SelAc:   bus = ac_q;
            SelIr:   bus = ir_q;
            SelPc:   bus = pc_q;
            SelMdr:  bus = mdr_q;
            SelImdr: bus = imdr_q;
            default: bus = '0;
        endcase
    end

    always_comb begin
        alu = bus;
        case (bus_if.operation)
            OpAdd:   alu = ac_q + bus;
            OpSub:   alu = ac_q - bus;
            OpShl:   alu = ac_q << 1;
            OpShr:   alu = ac_q >> 1;
            default: alu = bus;
        endcase
    end

    assign ac_inc = ac_q + One;

    always_comb begin
        pc_d   = pc_q;
        ir_d   = ir_q;
        ac_d   = ac_q;
        ar_d   = ar_q;
        mdr_d  = mdr_q;
        imdr_d = imdr_q;
        r_d    = r_q;
        z_d    = z_q;

        if (!bus_if.endp) begin
            case (bus_if.d_select)
                SelR1:   r_d[0] = bus;
                SelR2:   r_d[1] = bus;
                SelR3:   r_d[2] = bus;
                SelR4:   r_d[3] = bus;
                SelR5:   r_d[4] = bus;
                SelAr:   ar_d   = bus;
                SelIr:   ir_d   = bus;
                SelMdr:  mdr_d  = bus;
                SelImdr: imdr_d = bus;
                default: ;
            endcase

            // Memory capture overrides a same-edge bus load; IMDR uses the pre-edge PC.
            if (bus_if.read) begin
                imdr_d = bus_if.imem_rdata;
                mdr_d  = bus_if.dmem_rdata;
            end

            if (bus_if.resetac) begin
                ac_d = '0;
                z_d  = 1'b1;
            end else if (bus_if.incac) begin
                ac_d = ac_inc;
                z_d  = (ac_inc == '0);
            end else if (bus_if.d_select == SelAc) begin
                ac_d = alu;
                z_d  = (alu == '0);
            end

            if (bus_if.resetpc) begin
                pc_d = '0;
            end else if (bus_if.d_select == SelPc) begin
                pc_d = bus;
            end else if (bus_if.incpc) begin
                pc_d = pc_q + One;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q   <= '0;
            ir_q   <= '0;
            ac_q   <= '0;
            ar_q   <= '0;
            mdr_q  <= '0;
            imdr_q <= '0;
            for (int i = 0; i < 5; i++) begin
                r_q[i] <= '0;
            end
            z_q    <= 1'b1;
        end else begin
            pc_q   <= pc_d;
            ir_q   <= ir_d;
            ac_q   <= ac_d;
            ar_q   <= ar_d;
            mdr_q  <= mdr_d;
            imdr_q <= imdr_d;
            r_q    <= r_d;
            z_q    <= z_d;
        end
    end

    assign bus_if.imem_addr  = pc_q[IAW-1:0];
    assign bus_if.dmem_addr  = ar_q[DAW-1:0];
    assign bus_if.dmem_wdata = ac_q;
    assign bus_if.dmem_we    = bus_if.write & ~bus_if.endp;
    assign bus_if.ir         = ir_q;
    assign bus_if.z          = z_q;
    assign bus_if.ac         = ac_q;
endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed scenarios plus randomized control words,
// compared against a register-array reference model and small instruction/data memories.
module tb_cpu_datapath;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    cpu_datapath_if #(.DW(16), .IAW(8), .DAW(8)) dp_if ();

    cpu_datapath #(.DW(16), .IAW(8), .DAW(8)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (dp_if)
    );

    logic [15:0] imem [256];
    logic [15:0] dmem [256];

    assign dp_if.imem_rdata = imem[dp_if.imem_addr];
    assign dp_if.dmem_rdata = dmem[dp_if.dmem_addr];

    // Model state indexed by register code; entry 0 is unused.
    logic [15:0] m_reg [16];
    logic [15:0] m_nx  [16];
    logic        m_z;
    logic        m_znx;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_ctl(input logic [3:0] ds, input logic [3:0] ms, input logic [2:0] op,
                           input logic rd, input logic wr, input logic iac, input logic ipc,
                           input logic rac, input logic rpc, input logic ep);
        dp_if.d_select  = ds;
        dp_if.m_select  = ms;
        dp_if.operation = op;
        dp_if.read      = rd;
        dp_if.write     = wr;
        dp_if.incac     = iac;
        dp_if.incpc     = ipc;
        dp_if.resetac   = rac;
        dp_if.resetpc   = rpc;
        dp_if.endp      = ep;
    endtask

    task automatic idle();
        set_ctl(4'd0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic model_edge();
        logic [15:0] src;
        logic [15:0] res;
        logic [3:0]  ds;
        logic [3:0]  ms;
        ds = dp_if.d_select;
        ms = dp_if.m_select;
        m_nx  = m_reg;
        m_znx = m_z;
        src = (ms >= 4'd1 && ms <= 4'd11) ? m_reg[ms] : 16'h0000;
        case (dp_if.operation)
            3'd2:    res = m_reg[7] + src;
            3'd3:    res = m_reg[7] - src;
            3'd4:    res = {m_reg[7][14:0], 1'b0};
            3'd5:    res = {1'b0, m_reg[7][15:1]};
            default: res = src;
        endcase
        if (!rst_n) begin
            foreach (m_nx[i]) m_nx[i] = 16'h0000;
            m_znx = 1'b1;
        end else if (!dp_if.endp) begin
            if ((ds >= 4'd1 && ds <= 4'd6) || ds == 4'd8 || ds == 4'd10 || ds == 4'd11)
                m_nx[ds] = src;
            if (dp_if.read) begin
                m_nx[11] = imem[m_reg[9][7:0]];
                m_nx[10] = dmem[m_reg[6][7:0]];
            end
            if (dp_if.resetac) m_nx[7] = 16'h0000;
            else if (dp_if.incac) m_nx[7] = m_reg[7] + 16'd1;
            else if (ds == 4'd7) m_nx[7] = res;
            if (dp_if.resetac || dp_if.incac || ds == 4'd7) m_znx = (m_nx[7] == 16'h0000);
            if (dp_if.resetpc) m_nx[9] = 16'h0000;
            else if (ds == 4'd9) m_nx[9] = src;
            else if (dp_if.incpc) m_nx[9] = m_reg[9] + 16'd1;
        end
    endtask

    // One rising edge: pre-edge write-enable check, model update, post-edge output checks.
    task automatic step();
        logic       wr_en;
        logic [7:0] wr_a;
        logic [15:0] wr_d;
        @(negedge clk);
        check_eq("dmem_we", 16'(dp_if.dmem_we), 16'(dp_if.write & ~dp_if.endp));
        model_edge();
        wr_en = dp_if.dmem_we;
        wr_a  = dp_if.dmem_addr;
        wr_d  = dp_if.dmem_wdata;
        @(posedge clk);
        #1;
        if (wr_en) dmem[wr_a] = wr_d;
        m_reg = m_nx;
        m_z   = m_znx;
        check_eq("ac", dp_if.ac, m_reg[7]);
        check_eq("ir", dp_if.ir, m_reg[8]);
        check_eq("z", 16'(dp_if.z), 16'(m_z));
        check_eq("imem_addr", 16'(dp_if.imem_addr), 16'(m_reg[9][7:0]));
        check_eq("dmem_addr", 16'(dp_if.dmem_addr), 16'(m_reg[6][7:0]));
        check_eq("dmem_wdata", dp_if.dmem_wdata, m_reg[7]);
    endtask

    // Place a constant at the current PC, fetch it into IMDR, then move it to register 'code'.
    task automatic load_const(input logic [3:0] code, input logic [15:0] value);
        imem[m_reg[9][7:0]] = value;
        idle();
        dp_if.read = 1'b1;
        step();
        idle();
        dp_if.d_select = code;
        dp_if.m_select = 4'd11;
        step();
    endtask

    initial begin
        foreach (imem[i]) imem[i] = 16'($urandom);
        foreach (dmem[i]) dmem[i] = 16'($urandom);
        foreach (m_reg[i]) m_reg[i] = 16'h0000;
        m_z   = 1'b1;
        rst_n = 1'b0;
        idle();
        @(posedge clk);
        #1;

        step();
        check_eq("rst_ac", dp_if.ac, 16'h0000);
        check_eq("rst_ir", dp_if.ir, 16'h0000);
        check_eq("rst_z", 16'(dp_if.z), 16'h0001);
        check_eq("rst_pc", 16'(dp_if.imem_addr), 16'h0000);
        check_eq("rst_ar", 16'(dp_if.dmem_addr), 16'h0000);
        rst_n = 1'b1;

        idle();
        dp_if.incpc = 1'b1;
        repeat (3) step();
        check_eq("incpc3", 16'(dp_if.imem_addr), 16'h0003);
        dp_if.resetpc = 1'b1;
        step();
        check_eq("resetpc_prio", 16'(dp_if.imem_addr), 16'h0000);

        imem[0] = 16'h0023;
        idle();
        dp_if.read = 1'b1;
        step();
        idle();
        dp_if.d_select = 4'd8;
        dp_if.m_select = 4'd11;
        step();
        check_eq("fetch_ir", dp_if.ir, 16'h0023);

        load_const(4'd7, 16'h0005);
        load_const(4'd1, 16'h0003);
        set_ctl(4'd7, 4'd1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check_eq("add_ac", dp_if.ac, 16'h0008);
        check_eq("add_z", 16'(dp_if.z), 16'h0000);
        load_const(4'd1, 16'h0008);
        set_ctl(4'd7, 4'd1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check_eq("sub_ac", dp_if.ac, 16'h0000);
        check_eq("sub_z", 16'(dp_if.z), 16'h0001);
        load_const(4'd7, 16'h8001);
        set_ctl(4'd7, 4'd0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check_eq("shl_ac", dp_if.ac, 16'h0002);
        load_const(4'd7, 16'h8001);
        set_ctl(4'd7, 4'd0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check_eq("shr_ac", dp_if.ac, 16'h4000);

        load_const(4'd7, 16'hFFFF);
        set_ctl(4'd0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check_eq("incac_wrap", dp_if.ac, 16'h0000);
        check_eq("incac_wrap_z", 16'(dp_if.z), 16'h0001);
        load_const(4'd7, 16'h0005);
        set_ctl(4'd7, 4'd1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check_eq("incac_over_load", dp_if.ac, 16'h0006);
        set_ctl(4'd0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check_eq("resetac_prio", dp_if.ac, 16'h0000);
        check_eq("resetac_z", 16'(dp_if.z), 16'h0001);

        load_const(4'd6, 16'h0012);
        load_const(4'd7, 16'hBEEF);
        set_ctl(4'd0, 4'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check_eq("wr_we", 16'(dp_if.dmem_we), 16'h0001);
        check_eq("wr_addr", 16'(dp_if.dmem_addr), 16'h0012);
        check_eq("wr_data", dp_if.dmem_wdata, 16'hBEEF);
        step();
        set_ctl(4'd7, 4'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        check_eq("endp_we", 16'(dp_if.dmem_we), 16'h0000);
        step();
        check_eq("endp_ac_hold", dp_if.ac, 16'hBEEF);
        check_eq("endp_pc_hold", 16'(dp_if.imem_addr), 16'h0000);
        check_eq("dmem_written", dmem[8'h12], 16'hBEEF);

        load_const(4'd3, 16'h00AA);
        rst_n = 1'b0;
        set_ctl(4'd0, 4'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        check_eq("midrst_z", 16'(dp_if.z), 16'h0001);
        check_eq("midrst_ac", dp_if.ac, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            set_ctl(4'd8, (k == 0) ? 4'd3 : (k == 1) ? 4'd11 : 4'd10, 3'd0,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
            check_eq("midrst_reg", dp_if.ir, 16'h0000);
        end

        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            set_ctl(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    3'($urandom_range(0, 7)),
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 9) == 0));
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
